// File: rtl/hazard_unit_mdu.sv
// Hazard/forwarding unit for the 5-stage MIPS pipeline with a multi-cycle MDU busy scoreboard
// and a saturating stall-cycle counter.
module hazard_unit_mdu #(
   parameter int REG_AW      = 5,
   parameter int MUL_LATENCY = 4,
   parameter int DIV_LATENCY = 32,
   parameter int CNT_W       = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              BranchD,
   input  logic [REG_AW-1:0] RsD,
   input  logic [REG_AW-1:0] RtD,
   input  logic [REG_AW-1:0] RsE,
   input  logic [REG_AW-1:0] RtE,
   input  logic [REG_AW-1:0] WriteRegE,
   input  logic              RegWriteE,
   input  logic              MemToRegE,
   input  logic [REG_AW-1:0] WriteRegM,
   input  logic              RegWriteM,
   input  logic              MemToRegM,
   input  logic [REG_AW-1:0] WriteRegW,
   input  logic              RegWriteW,
   input  logic              MduStartE,
   input  logic              MduDivE,
   input  logic              MduStartD,
   input  logic              MduReadD,
   output logic              StallF,
   output logic              StallD,
   output logic              FlushE,
   output logic              ForwardAD,
   output logic              ForwardBD,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic              MduBusy,
   output logic [CNT_W-1:0]  StallCount
);

   localparam int BW = $clog2(DIV_LATENCY + 1);

   logic [BW-1:0]    busy_cnt_q, busy_cnt_d;
   logic             busy_q;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             lw_stall, br_stall, mdu_stall, stall;
   logic             e_hits_d, m_hits_d;

   // E-stage operand forwarding: M wins over W, register 0 never forwards
   always_comb begin
      ForwardAE = 2'b00;
      if (RsE != '0 && RsE == WriteRegM && RegWriteM)      ForwardAE = 2'b10;
      else if (RsE != '0 && RsE == WriteRegW && RegWriteW) ForwardAE = 2'b01;
      ForwardBE = 2'b00;
      if (RtE != '0 && RtE == WriteRegM && RegWriteM)      ForwardBE = 2'b10;
      else if (RtE != '0 && RtE == WriteRegW && RegWriteW) ForwardBE = 2'b01;
   end

   assign ForwardAD = (RsD != '0) && (RsD == WriteRegM) && RegWriteM;
   assign ForwardBD = (RtD != '0) && (RtD == WriteRegM) && RegWriteM;

   assign e_hits_d  = (WriteRegE != '0) && (WriteRegE == RsD || WriteRegE == RtD);
   assign m_hits_d  = (WriteRegM != '0) && (WriteRegM == RsD || WriteRegM == RtD);

   assign lw_stall  = MemToRegE && e_hits_d;
   assign br_stall  = BranchD && ((RegWriteE && e_hits_d) || (MemToRegM && m_hits_d));
   // MduStartE covers the start cycle itself, before the busy flag has risen
   assign mdu_stall = (MduReadD || MduStartD) && (busy_q || MduStartE);
   assign stall     = lw_stall | br_stall | mdu_stall;

   assign StallF = stall;
   assign StallD = stall;
   assign FlushE = stall;

   always_comb begin
      busy_cnt_d = busy_cnt_q;
      if (MduStartE)
         busy_cnt_d = MduDivE ? BW'(DIV_LATENCY) : BW'(MUL_LATENCY);
      else if (busy_cnt_q != '0)
         busy_cnt_d = busy_cnt_q - BW'(1);
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && !(&stall_cnt_q))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_cnt_q  <= '0;
         busy_q      <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         busy_cnt_q  <= busy_cnt_d;
         busy_q      <= (busy_cnt_d != '0);
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign MduBusy    = busy_q;
   assign StallCount = stall_cnt_q;

endmodule
